// File: rtl/i2s_mode_sequencer.sv
// i2s_mode_sequencer
//   Sequences a mode change on the I2S txrx block. A request is accepted only in IDLE.
//   Before the new config takes effect, the sequencer:
//     1. forces every enable low,
//     2. waits for both FIFOs to drain (bounded by a timeout),
//     3. holds a quiet gap of QUIET_CYC cycles,
//     4. applies the decoded config.
//   Requests that decode to the current config are no-ops.
//   Illegal slave modes are rejected with a one-cycle error pulse.
//
// Parameters
//   QUIET_CYC      cycles all enables stay low before the new config is applied (>= 1)
//   DRAIN_TIMEOUT  maximum cycles spent waiting for the FIFOs to drain (>= 2)
//
// Ports
//   clk_i, rst_i             clock; synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_slave_en_i           requested slave enable
//   req_slave_mode_i         0 = I2S, 1 = DSP, 2 = PDM, 3 = illegal
//   req_master_en_i          requested master enable
//   req_master_dsp_i         requested master DSP mode
//   rx/tx_fifo_empty_i       FIFO empty flags from the txrx block
//   cfg_*_o                  registered enables driven to the txrx block
//   busy_o                   high whenever a reconfiguration is in progress
//   err_mode_o               one-cycle pulse: illegal slave mode rejected
//   err_timeout_o            one-cycle pulse: FIFO drain timed out
module i2s_mode_sequencer #(
  parameter int unsigned QUIET_CYC     = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_slave_en_i,
  input  logic [1:0] req_slave_mode_i,
  input  logic       req_master_en_i,
  input  logic       req_master_dsp_i,
  input  logic       rx_fifo_empty_i,
  input  logic       tx_fifo_empty_i,
  output logic       cfg_slave_en_o,
  output logic       cfg_slave_dsp_en_o,
  output logic       cfg_slave_pdm_en_o,
  output logic       cfg_master_en_o,
  output logic       cfg_master_dsp_en_o,
  output logic       busy_o,
  output logic       err_mode_o,
  output logic       err_timeout_o
);

  localparam int unsigned DrainW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned QuietW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TIMEOUT - 1);
  localparam logic [QuietW-1:0] QuietLast = QuietW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {StIdle, StDrain, StQuiet, StApply} state_e;

  state_e            state_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic [QuietW-1:0] quiet_cnt_q;

  // Shadow copy of the accepted request.
  logic       sh_slave_en_q;
  logic [1:0] sh_mode_q;
  logic       sh_master_en_q;
  logic       sh_master_dsp_q;

  // Bit order: {slave_en, slave_dsp_en, slave_pdm_en, master_en, master_dsp_en}.
  logic [4:0] cfg_q;
  logic       err_mode_q;
  logic       err_timeout_q;

  logic [4:0] req_cfg;
  logic [4:0] sh_cfg;
  logic       req_mode_bad;
  logic       fifos_empty;

  // The one-hot mode compare keeps DSP and PDM mutually exclusive.
  // Master DSP is gated by master_en.
  always_comb begin
    req_cfg = {req_slave_en_i,
               req_slave_en_i & (req_slave_mode_i == 2'd1),
               req_slave_en_i & (req_slave_mode_i == 2'd2),
               req_master_en_i,
               req_master_en_i & req_master_dsp_i};
    sh_cfg  = {sh_slave_en_q,
               sh_slave_en_q & (sh_mode_q == 2'd1),
               sh_slave_en_q & (sh_mode_q == 2'd2),
               sh_master_en_q,
               sh_master_en_q & sh_master_dsp_q};
  end

  assign req_mode_bad = req_slave_en_i & (req_slave_mode_i == 2'd3);
  assign fifos_empty  = rx_fifo_empty_i & tx_fifo_empty_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      drain_cnt_q     <= '0;
      quiet_cnt_q     <= '0;
      sh_slave_en_q   <= 1'b0;
      sh_mode_q       <= 2'd0;
      sh_master_en_q  <= 1'b0;
      sh_master_dsp_q <= 1'b0;
      cfg_q           <= '0;
      err_mode_q      <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      err_mode_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            sh_slave_en_q   <= req_slave_en_i;
            sh_mode_q       <= req_slave_mode_i;
            sh_master_en_q  <= req_master_en_i;
            sh_master_dsp_q <= req_master_dsp_i;
            if (req_mode_bad) begin
              err_mode_q <= 1'b1;
            end else if (req_cfg != cfg_q) begin
              // Enables drop immediately so the txrx block stops before the drain.
              cfg_q       <= '0;
              drain_cnt_q <= '0;
              state_q     <= StDrain;
            end
          end
        end
        StDrain: begin
          // An empty sample wins over a coincident timeout.
          if (fifos_empty) begin
            quiet_cnt_q <= '0;
            state_q     <= StQuiet;
          end else if (drain_cnt_q == DrainLast) begin
            err_timeout_q <= 1'b1;
            quiet_cnt_q   <= '0;
            state_q       <= StQuiet;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        StQuiet: begin
          if (quiet_cnt_q == QuietLast) begin
            state_q <= StApply;
          end else begin
            quiet_cnt_q <= quiet_cnt_q + 1'b1;
          end
        end
        StApply: begin
          cfg_q   <= sh_cfg;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o         = (state_q == StIdle);
  assign busy_o              = (state_q != StIdle);
  assign cfg_slave_en_o      = cfg_q[4];
  assign cfg_slave_dsp_en_o  = cfg_q[3];
  assign cfg_slave_pdm_en_o  = cfg_q[2];
  assign cfg_master_en_o     = cfg_q[1];
  assign cfg_master_dsp_en_o = cfg_q[0];
  assign err_mode_o          = err_mode_q;
  assign err_timeout_o       = err_timeout_q;

endmodule

// File: doc/i2s_mode_sequencer.md
I2S_MODE_SEQUENCER -- requirements
Module: i2s_mode_sequencer

Interface
REQ-001 SHALL have parameter QUIET_CYC, default 16 (>=1); meaning: cycles all enables are held low before a new config is applied.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 1024 (>=2); meaning: maximum cycles spent waiting for the FIFOs to drain.
REQ-003 SHALL have port clk_i, input, 1 bit; the single clock, all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit; a new config request is present.
REQ-006 SHALL have port req_ready_o, output, 1 bit; the sequencer accepts a request.
REQ-007 SHALL have port req_slave_en_i, input, 1 bit; requested slave enable.
REQ-008 SHALL have port req_slave_mode_i, input, 2 bits; 0 = I2S, 1 = DSP, 2 = PDM, 3 = illegal.
REQ-009 SHALL have port req_master_en_i, input, 1 bit; requested master enable.
REQ-010 SHALL have port req_master_dsp_i, input, 1 bit; requested master DSP mode.
REQ-011 SHALL have port rx_fifo_empty_i, input, 1 bit; RX FIFO empty.
REQ-012 SHALL have port tx_fifo_empty_i, input, 1 bit; TX FIFO empty.
REQ-013 SHALL have registered outputs cfg_slave_en_o, cfg_slave_dsp_en_o, cfg_slave_pdm_en_o, cfg_master_en_o and cfg_master_dsp_en_o, each 1 bit; these are the enables driven to the txrx block.
REQ-014 SHALL have port busy_o, output, 1 bit; high whenever the state is not IDLE.
REQ-015 SHALL have ports err_mode_o and err_timeout_o, output, 1 bit each; each is a one-cycle error pulse.

Function
REQ-016 SHALL implement the states IDLE, DRAIN, QUIET and APPLY.
REQ-017 SHALL drive req_ready_o = 1 only in IDLE; req_valid_i SHALL be ignored in every other state.
REQ-018 SHALL treat a request as accepted on a cycle where req_valid_i & req_ready_o; on acceptance, all req_* fields SHALL be latched into a shadow register.
REQ-019 SHALL reject an accepted request with req_slave_en_i=1 and req_slave_mode_i=3: err_mode_o pulses on the next cycle, the state stays IDLE and the cfg outputs are unchanged.
REQ-020 SHALL ignore mode when req_slave_en_i=0; mode 3 is legal in that case.
REQ-021 SHALL, on an accepted request whose decoded outputs equal the current cfg outputs, stay IDLE with no output glitch and no pulse.
REQ-022 SHALL, on any other accepted request, move to DRAIN, with all five cfg outputs going to 0 on the next cycle.
REQ-023 SHALL, in DRAIN, move to QUIET in the cycle after sampling rx_fifo_empty_i & tx_fifo_empty_i = 1.
REQ-024 SHALL, in DRAIN, count cycles from 0; if the count reaches DRAIN_TIMEOUT-1 without both FIFOs empty, err_timeout_o pulses for one cycle and the state moves to QUIET.
REQ-025 SHALL, in QUIET, hold all outputs at 0 for exactly QUIET_CYC cycles, then move to APPLY.
REQ-026 SHALL, in APPLY (one cycle), load the cfg outputs from the decoded shadow and return to IDLE; the new values SHALL be visible on the cycle after APPLY.
REQ-027 SHALL decode the shadow as follows:
- cfg_slave_en = slave_en
- cfg_slave_dsp_en = slave_en & (mode == 1)
- cfg_slave_pdm_en = slave_en & (mode == 2)
- cfg_master_en = master_en
- cfg_master_dsp_en = master_en & master_dsp
REQ-028 SHALL never assert cfg_slave_dsp_en_o and cfg_slave_pdm_en_o together.
REQ-029 SHALL never assert cfg_master_dsp_en_o without cfg_master_en_o.
REQ-030 SHALL, with both FIFOs empty, have a latency from the acceptance cycle to the first cycle showing the new cfg of QUIET_CYC+3 cycles (19 with the defaults).
REQ-031 SHALL size the drain and quiet counters to their parameter widths; neither counter SHALL wrap.
REQ-032 SHALL, when both error conditions could occur, give err_mode_o precedence; the two error pulses are mutually exclusive by construction.

Reset
REQ-033 SHALL, with rst_i high at a clock edge, set the following regardless of state (including mid-DRAIN or mid-QUIET):
- state = IDLE
- all cfg outputs = 0
- shadow = 0
- counters = 0
- err pulses = 0
REQ-034 SHALL drive req_ready_o = 1 and busy_o = 0 in the first cycle after reset deasserts.

Verification
REQ-035 SHALL pass this scenario: request slave_en=1, mode=2, master_en=1, dsp=1, with FIFOs empty, accepted at cycle 0 -> outputs 0 during cycles 1-18; from cycle 19 slave_en=1, pdm=1, dsp=0, master_en=1, master_dsp=1; busy_o high for cycles 1-18.
REQ-036 SHALL pass this scenario: rx_fifo_empty_i held 0 for 40 cycles after acceptance -> err_timeout_o stays 0; QUIET starts in the cycle after the empty sample; no error.
REQ-037 SHALL pass this scenario: rx_fifo_empty_i stuck at 0 with DRAIN_TIMEOUT=8 -> err_timeout_o pulses exactly once; the new cfg is still applied QUIET_CYC+1 cycles later.
REQ-038 SHALL pass this scenario: request slave_en=1, mode=3 -> err_mode_o is a one-cycle pulse; the cfg outputs are unchanged; busy_o stays 0.
REQ-039 SHALL pass this scenario: a request identical to the current cfg -> no output toggles and req_ready_o stays 1; then a request during QUIET with req_valid_i=1 -> it is not accepted until IDLE.
REQ-040 SHALL pass this scenario: rst_i pulsed for one cycle mid-QUIET -> all outputs 0 and IDLE on the next cycle; a subsequent request follows the full latency of REQ-030.
